// File: rtl/memory_access_unit.sv
// Memory-stage load/store unit: IDLE/BUSY/DONE handshake to a valid/ready data bus with lane extraction.
// Define MEM_MISALIGN_TRAP_EN to flag misaligned accesses instead of silently aligning them.
module memory_access_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [2:0]            Funct3M,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  StallM,
    output logic                  MisalignM,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state;
    logic                    access;
    logic                    trap;
    logic [1:0]              lo;
    logic [3:0]              be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [2:0]              ld_f3;
    logic [1:0]              ld_lo;
    logic [7:0]              byte_lane;
    logic [15:0]             half_lane;
    logic [DATA_WIDTH-1:0]   load_val;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned;
    always_comb begin
        misaligned = ((Funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                     ((Funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));
        trap       = misaligned;
        lo         = ALUResultM[1:0];
    end
    assign MisalignM = rst_n && (state == IDLE) && (MemReadM || MemWriteM) && misaligned;
`else
    // Without the trap, misaligned halves/words are forced onto their natural boundary.
    always_comb begin
        trap = 1'b0;
        lo   = ALUResultM[1:0];
        if (Funct3M[1:0] == 2'b10)
            lo = 2'b00;
        else if (Funct3M[1:0] == 2'b01)
            lo[0] = 1'b0;
    end
    assign MisalignM = 1'b0;
`endif

    assign access = (MemReadM || MemWriteM) && !trap;

    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        be    = 4'b1111;
        wdata = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                be    = 4'b0001 << lo;
                wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << {lo[1], 1'b0};
                wdata = {2{WriteDataM[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_lane = mem_rdata[8*ld_lo +: 8];
        half_lane = mem_rdata[16*ld_lo[1] +: 16];
        load_val  = mem_rdata;
        case (ld_f3[1:0])
            2'b00:   load_val = {{24{~ld_f3[2] & byte_lane[7]}}, byte_lane};
            2'b01:   load_val = {{16{~ld_f3[2] & half_lane[15]}}, half_lane};
            default: ;
        endcase
    end

    // Reset gates the stall so a flushed pipeline is released in the reset cycle.
    always_comb begin
        StallM = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE:    StallM = access;
                BUSY:    StallM = 1'b1;
                default: StallM = 1'b0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ReadDataM <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
            ld_f3     <= 3'b000;
            ld_lo     <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWriteM;
                        mem_addr  <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
                        mem_be    <= be;
                        mem_wdata <= wdata;
                        ld_f3     <= Funct3M;
                        ld_lo     <= lo;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (!mem_we)
                            ReadDataM <= load_val;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;  // DONE never re-issues the held instruction
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: table of single accesses plus back-to-back, reset and misalign sequences.
module tb_memory_access_unit;

    logic        clk;
    logic        rst_n;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MisalignM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int req_rises = 0;
    logic req_prev = 1'b0;

    memory_access_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_req && !req_prev) req_rises++;
        req_prev = mem_req;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        mem_ready = 1'b0;
    endtask

    // Presents one instruction and plays the bus slave; returns in the cycle StallM first reads 0.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                              input int ready_at, output int stall, output logic we_o,
                              output logic [31:0] addr_o, output logic [3:0] be_o,
                              output logic [31:0] wd_o, output logic mis_o, output logic done);
        int busy = 0;
        bit seen = 0;
        stall = 0; we_o = 1'b0; addr_o = '0; be_o = '0; wd_o = '0; mis_o = 1'b0; done = 1'b0;
        @(negedge clk);
        MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = a; WriteDataM = wd;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (cyc == 0) mis_o = MisalignM;
            mem_ready = 1'b0;
            if (mem_req) begin
                busy++;
                if (!seen) begin
                    we_o = mem_we; addr_o = mem_addr; be_o = mem_be; wd_o = mem_wdata;
                    seen = 1;
                end
                if (busy == ready_at) begin
                    mem_ready = 1'b1;
                    mem_rdata = rdata;
                end
            end
            if (!StallM) begin
                done = 1'b1;
                break;
            end
            stall++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          ready_at;
        int          exp_stall;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdm;
    } vec_t;

    vec_t vecs[11];

    int          st;
    logic        we_c, mis_c, ok;
    logic [31:0] addr_c, wd_c, rdm_before;
    logic [3:0]  be_c;
    int          st2, rises0;

    initial begin
        vecs[0]  = '{"lw_100",   1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 3, 4, 0, 32'h100, 4'b1111, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{"lb_103",   1, 0, 3'b000, 32'h103, 32'h0,        32'h80112233, 1, 2, 0, 32'h100, 4'b1000, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{"lbu_103",  1, 0, 3'b100, 32'h103, 32'h0,        32'h80112233, 1, 2, 0, 32'h100, 4'b1000, 32'h0,        32'h00000080};
        vecs[3]  = '{"lh_102",   1, 0, 3'b001, 32'h102, 32'h0,        32'h80112233, 1, 2, 0, 32'h100, 4'b1100, 32'h0,        32'hFFFF8011};
        vecs[4]  = '{"sh_102",   0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'hFFFFFFFF, 2, 3, 1, 32'h100, 4'b1100, 32'hABCDABCD, 32'hFFFF8011};
        vecs[5]  = '{"lhu_200",  1, 0, 3'b101, 32'h200, 32'h0,        32'h1234F00D, 1, 2, 0, 32'h200, 4'b0011, 32'h0,        32'h0000F00D};
        vecs[6]  = '{"lb_201",   1, 0, 3'b000, 32'h201, 32'h0,        32'h00007F00, 1, 2, 0, 32'h200, 4'b0010, 32'h0,        32'h0000007F};
        vecs[7]  = '{"sb_001",   0, 1, 3'b000, 32'h001, 32'h000000A5, 32'hFFFFFFFF, 4, 5, 1, 32'h000, 4'b0010, 32'hA5A5A5A5, 32'h0000007F};
        vecs[8]  = '{"sw_10c",   0, 1, 3'b010, 32'h10C, 32'hCAFEBABE, 32'hFFFFFFFF, 1, 2, 1, 32'h10C, 4'b1111, 32'hCAFEBABE, 32'h0000007F};
        vecs[9]  = '{"lh_006",   1, 0, 3'b001, 32'h006, 32'h0,        32'h80000000, 1, 2, 0, 32'h004, 4'b1100, 32'h0,        32'hFFFF8000};
        vecs[10] = '{"lb_002",   1, 0, 3'b000, 32'h002, 32'h0,        32'h00FE0000, 1, 2, 0, 32'h000, 4'b0100, 32'h0,        32'hFFFFFFFE};

        rst_n = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
        ALUResultM = '0; WriteDataM = '0; mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ReadDataM", ReadDataM, 32'h0);
        check("rst_mem_req",   {31'b0, mem_req}, 32'h0);
        check("rst_mem_we",    {31'b0, mem_we}, 32'h0);
        check("rst_mem_addr",  mem_addr, 32'h0);
        check("rst_mem_be",    {28'b0, mem_be}, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_StallM",    {31'b0, StallM}, 32'h0);
        check("rst_MisalignM", {31'b0, MisalignM}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_access(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd, vecs[i].rdata,
                       vecs[i].ready_at, st, we_c, addr_c, be_c, wd_c, mis_c, ok);
            check({vecs[i].name, "_done"},  {31'b0, ok}, 32'h1);
            check({vecs[i].name, "_stall"}, st, vecs[i].exp_stall);
            check({vecs[i].name, "_we"},    {31'b0, we_c}, {31'b0, vecs[i].exp_we});
            check({vecs[i].name, "_addr"},  addr_c, vecs[i].exp_addr);
            check({vecs[i].name, "_be"},    {28'b0, be_c}, {28'b0, vecs[i].exp_be});
            check({vecs[i].name, "_wdata"}, wd_c, vecs[i].exp_wdata);
            check({vecs[i].name, "_mis"},   {31'b0, mis_c}, 32'h0);
            check({vecs[i].name, "_rdm"},   ReadDataM, vecs[i].exp_rdm);
        end

`ifdef MEM_MISALIGN_TRAP_EN
        idle_inputs();
        rdm_before = ReadDataM;
        rises0 = req_rises;
        @(negedge clk);
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h101; WriteDataM = '0;
        #1;
        check("trap_MisalignM", {31'b0, MisalignM}, 32'h1);
        check("trap_StallM",    {31'b0, StallM}, 32'h0);
        @(negedge clk);
        #1;
        check("trap_mem_req",   {31'b0, mem_req}, 32'h0);
        check("trap_ReadDataM", ReadDataM, rdm_before);
        check("trap_no_req",    req_rises - rises0, 0);
`else
        run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0BADF00D, 1, st, we_c, addr_c, be_c, wd_c, mis_c, ok);
        check("mis_lw_stall", st, 2);
        check("mis_lw_addr",  addr_c, 32'h100);
        check("mis_lw_be",    {28'b0, be_c}, 32'hF);
        check("mis_lw_mis",   {31'b0, mis_c}, 32'h0);
        check("mis_lw_rdm",   ReadDataM, 32'h0BADF00D);
`endif

        // Back-to-back LW then SB with ready in the first BUSY cycle.
        rises0 = req_rises;
        run_access(1'b1, 1'b0, 3'b010, 32'h040, 32'h0, 32'h11223344, 1, st, we_c, addr_c, be_c, wd_c, mis_c, ok);
        check("b2b_lw_stall", st, 2);
        check("b2b_lw_rdm",   ReadDataM, 32'h11223344);
        run_access(1'b0, 1'b1, 3'b000, 32'h001, 32'h0000005A, 32'hFFFFFFFF, 1, st2, we_c, addr_c, be_c, wd_c, mis_c, ok);
        check("b2b_sb_stall", st2, 2);
        check("b2b_sb_be",    {28'b0, be_c}, 32'h2);
        check("b2b_sb_wdata", wd_c, 32'h5A5A5A5A);
        check("b2b_sb_rdm",   ReadDataM, 32'h11223344);
        idle_inputs();
        repeat (3) @(negedge clk);
        check("b2b_req_pulses", req_rises - rises0, 2);

        // Reset while a load is waiting on the bus.
        @(negedge clk);
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h300; mem_ready = 1'b0;
        @(negedge clk);
        #1;
        check("rb_req_up", {31'b0, mem_req}, 32'h1);
        @(negedge clk);
        #1;
        check("rb_still_busy", {31'b0, StallM}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("rb_mem_req",   {31'b0, mem_req}, 32'h0);
        check("rb_StallM",    {31'b0, StallM}, 32'h0);
        check("rb_ReadDataM", ReadDataM, 32'h0);
        MemReadM = 1'b0;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        #1;
        check("late_ready_req",   {31'b0, mem_req}, 32'h0);
        check("late_ready_stall", {31'b0, StallM}, 32'h0);
        check("late_ready_rdm",   ReadDataM, 32'h0);
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        check("late_ready_idle", {31'b0, StallM}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
